// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: word/byte/indirect loads and stores plus trap reads, with stall/access counters.
// Define MEM_TIMEOUT_EN to add a per-access watchdog that aborts a stuck access with error=1.
module mem_stage_ctrl #(
  parameter int WIDTH          = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     addr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 mem_resp,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic [WIDTH/8-1:0]   mem_wmask,
  output logic                 stall,
  output logic                 done,
  output logic [WIDTH-1:0]     rdata,
  output logic                 trap_en,
  output logic                 error,
  input  logic                 count_clear,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] access_count,
  output logic [1:0]           dbg_state_o
);
  localparam int NB = WIDTH / 8;
  localparam int LW = $clog2(NB);

  localparam logic [2:0] OP_NONE = 3'd0, OP_LDW = 3'd1, OP_STW = 3'd2, OP_LDB = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4, OP_LDI = 3'd5, OP_STI = 3'd6, OP_TRAP = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRST = 2'd1, S_SECOND = 2'd2, S_DONE = 2'd3} state_t;

  state_t               state_q;
  logic [2:0]           op_q;
  logic [LW-1:0]        lane_q;
  logic [WIDTH-1:0]     wdata_q, rdata_q, mem_addr_q, mem_wdata_q;
  logic [NB-1:0]        mem_wmask_q;
  logic                 mem_read_q, mem_write_q, done_q, trap_en_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, access_cnt_q, access_cnt_d;

  logic          busy, accept, resp_ok, expire;
  logic [LW-1:0] lane_in;
  logic [7:0]    rbyte;

  assign busy    = (state_q == S_FIRST) || (state_q == S_SECOND);
  assign accept  = (state_q == S_IDLE) && valid && (op != OP_NONE);
  assign resp_ok = busy && mem_resp;
  assign lane_in = addr[LW-1:0];
  assign rbyte   = 8'(mem_rdata >> {lane_q, 3'b000});

`ifdef MEM_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;
  logic           error_q;
  // Counts resp-less cycles of the current access; fires on the last allowed cycle.
  assign expire = busy && !mem_resp && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
  assign error  = error_q;
`else
  assign expire = 1'b0;
  assign error  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      lane_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      trap_en_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wd_q        <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_FIRST;
            op_q        <= op;
            lane_q      <= lane_in;
            wdata_q     <= wdata;
            mem_addr_q  <= addr;
            mem_read_q  <= (op == OP_LDW) || (op == OP_LDB) || (op >= OP_LDI);
            mem_write_q <= (op == OP_STW) || (op == OP_STB);
            if (op == OP_STB) begin
              mem_wmask_q <= NB'(1) << lane_in;
              mem_wdata_q <= WIDTH'(wdata[7:0]) << {lane_in, 3'b000};
            end else begin
              mem_wmask_q <= '1;
              mem_wdata_q <= wdata;
            end
`ifdef MEM_TIMEOUT_EN
            wd_q <= '0;
`endif
          end
        end
        S_FIRST, S_SECOND: begin
          // Indirect ops turn the first read's data into the second access address.
          if (mem_resp && (state_q == S_FIRST) && ((op_q == OP_LDI) || (op_q == OP_STI))) begin
            state_q     <= S_SECOND;
            mem_addr_q  <= mem_rdata;
            mem_read_q  <= (op_q == OP_LDI);
            mem_write_q <= (op_q == OP_STI);
            mem_wmask_q <= '1;
            mem_wdata_q <= wdata_q;
`ifdef MEM_TIMEOUT_EN
            wd_q <= '0;
`endif
          end else if (mem_resp || expire) begin
            state_q     <= S_DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            trap_en_q   <= (op_q == OP_TRAP);
`ifdef MEM_TIMEOUT_EN
            error_q     <= expire;
`endif
            if (mem_resp) begin
              if (op_q == OP_LDB) begin
                rdata_q <= WIDTH'(rbyte);
              end else if ((op_q == OP_LDW) || (op_q == OP_LDI) || (op_q == OP_TRAP)) begin
                rdata_q <= mem_rdata;
              end
            end
          end else begin
`ifdef MEM_TIMEOUT_EN
            wd_q <= wd_q + WDW'(1);
`endif
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
          trap_en_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          error_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    access_cnt_d = access_cnt_q;
    if (count_clear) begin
      stall_cnt_d  = '0;
      access_cnt_d = '0;
    end else begin
      if (stall && !(&stall_cnt_q))    stall_cnt_d  = stall_cnt_q + CNT_WIDTH'(1);
      if (resp_ok && !(&access_cnt_q)) access_cnt_d = access_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      access_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      access_cnt_q <= access_cnt_d;
    end
  end

  assign stall        = busy || accept;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wmask    = mem_wmask_q;
  assign done         = done_q;
  assign trap_en      = trap_en_q;
  assign rdata        = rdata_q;
  assign stall_count  = stall_cnt_q;
  assign access_count = access_cnt_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-op expected cycle traces in a queue, checked every negedge.
// Build with MEM_TIMEOUT_EN defined to exercise the watchdog abort instead of the endless wait.
module tb_mem_stage_ctrl;
  localparam int W    = 16;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk, reset_n, valid, mem_resp, count_clear;
  logic [2:0]    op;
  logic [W-1:0]  addr, wdata, mem_rdata;
  logic          mem_read, mem_write, stall, done, trap_en, error;
  logic [W-1:0]  mem_addr, mem_wdata, rdata;
  logic [1:0]    mem_wmask, dbg_state;
  logic [CW-1:0] stall_count, access_count;

  mem_stage_ctrl #(.WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .op(op), .addr(addr), .wdata(wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .stall(stall),
    .done(done), .rdata(rdata), .trap_en(trap_en), .error(error), .count_clear(count_clear),
    .stall_count(stall_count), .access_count(access_count), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [W-1:0]  addr;
    logic [W-1:0]  wdata;
    logic [1:0]    wmask;
    logic          stall;
    logic          done;
    logic          trap;
    logic          err;
    logic          chk_rdata;
    logic [W-1:0]  rdata;
    logic [CW-1:0] scnt;
    logic [CW-1:0] acnt;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int m_scnt   = 0;
  int m_acnt   = 0;
  logic [W-1:0] m_rdata = '0;
  logic [W-1:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic [1:0]   last_wr_mask = '0;
  int done_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: one expected entry per driven cycle
  always @(negedge clk) begin : compare
    exp_t e;
    logic [W-1:0] bm;
    if (mem_read) last_rd_addr = mem_addr;
    if (mem_write) begin
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
      last_wr_mask = mem_wmask;
    end
    if (done) done_pulses++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_read", 32'(mem_read), 32'(e.rd));
      chk("mem_write", 32'(mem_write), 32'(e.wr));
      chk("stall", 32'(stall), 32'(e.stall));
      chk("done", 32'(done), 32'(e.done));
      chk("trap_en", 32'(trap_en), 32'(e.trap));
      chk("error", 32'(error), 32'(e.err));
      chk("stall_count", 32'(stall_count), 32'(e.scnt));
      chk("access_count", 32'(access_count), 32'(e.acnt));
      if (e.rd || e.wr) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      if (e.wr) begin
        bm = {{8{e.wmask[1]}}, {8{e.wmask[0]}}};
        chk("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
        chk("mem_wdata", 32'(mem_wdata & bm), 32'(e.wdata & bm));
      end
      if (e.chk_rdata) chk("rdata", 32'(rdata), 32'(e.rdata));
    end
  end

  // driver: push this cycle's expectation, advance the counter model, move to next cycle
  task automatic step(input exp_t e_in, input bit acc, input bit clr);
    exp_t e;
    e = e_in;
    e.scnt = CW'(m_scnt);
    e.acnt = CW'(m_acnt);
    exp_q.push_back(e);
    if (clr) begin
      m_scnt = 0;
      m_acnt = 0;
    end else begin
      if (e.stall && m_scnt < MAXC) m_scnt++;
      if (acc && m_acnt < MAXC) m_acnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // lat = resp-less cycles before the responding cycle of each phase
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input int lat1, input logic [W-1:0] d1,
                        input int lat2, input logic [W-1:0] d2, input bit clr_last);
    exp_t e;
    bit two, is_load;
    int lane;
    logic [W-1:0] fin;
    two     = (o == 3'd5) || (o == 3'd6);
    is_load = (o == 3'd1) || (o == 3'd3) || (o == 3'd5) || (o == 3'd7);
    lane    = int'(a[0]);
    valid = 1'b1; op = o; addr = a; wdata = wd; mem_resp = 1'b0; count_clear = 1'b0;
    e = '0; e.stall = 1'b1;
    step(e, 1'b0, 1'b0);
    valid = 1'b0; op = 3'd0; addr = W'($urandom); wdata = W'($urandom);
    for (int i = 0; i <= lat1; i++) begin
      mem_resp  = (i == lat1);
      mem_rdata = (i == lat1) ? d1 : W'($urandom);
      count_clear = clr_last && !two && (i == lat1);
      e = '0;
      e.stall = 1'b1;
      e.rd    = o inside {3'd1, 3'd3, 3'd5, 3'd6, 3'd7};
      e.wr    = o inside {3'd2, 3'd4};
      e.addr  = a;
      e.wmask = (o == 3'd4) ? 2'(1 << lane) : 2'b11;
      e.wdata = (o == 3'd4) ? (16'(wd[7:0]) << (8 * lane)) : wd;
      step(e, i == lat1, count_clear);
    end
    fin = d1;
    if (two) begin
      for (int i = 0; i <= lat2; i++) begin
        mem_resp  = (i == lat2);
        mem_rdata = (i == lat2) ? d2 : W'($urandom);
        count_clear = clr_last && (i == lat2);
        e = '0;
        e.stall = 1'b1;
        e.rd    = (o == 3'd5);
        e.wr    = (o == 3'd6);
        e.addr  = d1;
        e.wmask = 2'b11;
        e.wdata = wd;
        step(e, i == lat2, count_clear);
      end
      fin = d2;
    end
    // DONE: a stray resp and a new request must both be ignored
    mem_resp = 1'b1; mem_rdata = W'($urandom); valid = 1'b1; op = 3'd1; count_clear = 1'b0;
    if (o == 3'd3) m_rdata = (fin >> (8 * lane)) & 16'h00FF;
    else if (is_load) m_rdata = fin;
    e = '0; e.done = 1'b1; e.trap = (o == 3'd7); e.chk_rdata = is_load; e.rdata = m_rdata;
    step(e, 1'b0, 1'b0);
    valid = 1'b0; op = 3'd0; mem_resp = 1'b0;
    e = '0; e.chk_rdata = is_load; e.rdata = m_rdata;
    step(e, 1'b0, 1'b0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic run_timeout(input logic [W-1:0] a);
    exp_t e;
    valid = 1'b1; op = 3'd1; addr = a; mem_resp = 1'b0;
    e = '0; e.stall = 1'b1;
    step(e, 1'b0, 1'b0);
    valid = 1'b0; op = 3'd0;
    for (int i = 0; i < TO; i++) begin
      e = '0; e.stall = 1'b1; e.rd = 1'b1; e.addr = a; e.wmask = 2'b11;
      step(e, 1'b0, 1'b0);
    end
    e = '0; e.done = 1'b1; e.err = 1'b1; e.chk_rdata = 1'b1; e.rdata = m_rdata;
    step(e, 1'b0, 1'b0);
    e = '0; e.chk_rdata = 1'b1; e.rdata = m_rdata;
    step(e, 1'b0, 1'b0);
  endtask
`endif

  initial begin : main
    exp_t e;
    int d0;
    reset_n = 1'b0; valid = 1'b0; op = 3'd0; addr = '0; wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0; count_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_counts", 32'({stall_count, access_count}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;

    // ldw, resp on the second FIRST cycle, done on cycle 4
    run_op(3'd1, 16'h3000, 16'h0000, 1, 16'hBEEF, 0, '0, 1'b0);
    chk("ldw_rdata", 32'(rdata), 32'h0000BEEF);
    chk("ldw_access_count", 32'(access_count), 32'd1);
    chk("ldw_stall_count", 32'(stall_count), 32'd3);

    run_op(3'd4, 16'h3001, 16'h00A5, 0, 16'h0000, 0, '0, 1'b0);
    chk("stb_hi_mask", 32'(last_wr_mask), 32'h2);
    chk("stb_hi_lane", 32'(last_wr_data[15:8]), 32'hA5);
    run_op(3'd4, 16'h3000, 16'h00A5, 2, 16'h0000, 0, '0, 1'b0);
    chk("stb_lo_mask", 32'(last_wr_mask), 32'h1);
    chk("stb_lo_lane", 32'(last_wr_data[7:0]), 32'hA5);

    d0 = done_pulses;
    run_op(3'd6, 16'h4000, 16'h1234, 1, 16'h5000, 2, 16'h0000, 1'b0);
    chk("sti_read_addr", 32'(last_rd_addr), 32'h4000);
    chk("sti_write_addr", 32'(last_wr_addr), 32'h5000);
    chk("sti_write_data", 32'(last_wr_data), 32'h1234);
    chk("sti_done_pulses", 32'(done_pulses - d0), 32'd1);

    run_op(3'd3, 16'h2001, 16'h0000, 0, 16'hC37E, 0, '0, 1'b0);
    chk("ldb_hi_rdata", 32'(rdata), 32'h00C3);
    run_op(3'd3, 16'h2000, 16'h0000, 1, 16'hC37E, 0, '0, 1'b0);
    chk("ldb_lo_rdata", 32'(rdata), 32'h007E);
    run_op(3'd2, 16'h2222, 16'hFACE, 1, 16'h0000, 0, '0, 1'b0);
    run_op(3'd5, 16'h1000, 16'h0000, 0, 16'h2000, 3, 16'h9999, 1'b0);
    chk("ldi_rdata", 32'(rdata), 32'h9999);
    run_op(3'd7, 16'h0100, 16'h0000, 2, 16'h0BAD, 0, '0, 1'b0);

    // op 0 with valid is not a request
    valid = 1'b1; op = 3'd0; addr = 16'h5555;
    e = '0;
    step(e, 1'b0, 1'b0);
    step(e, 1'b0, 1'b0);
    valid = 1'b0;

    // ldi interrupted by reset while in SECOND
    wdata = '0;
    valid = 1'b1; op = 3'd5; addr = 16'h4100; mem_resp = 1'b0;
    e = '0; e.stall = 1'b1;
    step(e, 1'b0, 1'b0);
    valid = 1'b0; op = 3'd0; mem_resp = 1'b1; mem_rdata = 16'h4200;
    e = '0; e.stall = 1'b1; e.rd = 1'b1; e.addr = 16'h4100; e.wmask = 2'b11;
    step(e, 1'b1, 1'b0);
    mem_resp = 1'b0;
    e = '0; e.stall = 1'b1; e.rd = 1'b1; e.addr = 16'h4200; e.wmask = 2'b11;
    step(e, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_counts", 32'({stall_count, access_count}), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    m_scnt = 0; m_acnt = 0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_op(3'd1, 16'h3000, 16'h0000, 2, 16'h7777, 0, '0, 1'b0);
    chk("postrst_rdata", 32'(rdata), 32'h7777);
    chk("postrst_access", 32'(access_count), 32'd1);
    chk("postrst_stall", 32'(stall_count), 32'd4);

`ifdef MEM_TIMEOUT_EN
    run_timeout(16'h3300);
    chk("timeout_rdata_held", 32'(rdata), 32'h7777);
`else
    run_op(3'd1, 16'h3300, 16'h0000, 100, 16'h4444, 0, '0, 1'b0);
    chk("longwait_rdata", 32'(rdata), 32'h4444);
`endif

    for (int i = 0; i < 16; i++) begin
      run_op(3'd1, 16'(i * 2), 16'h0000, 0, 16'($urandom), 0, '0, 1'b0);
    end
    chk("sat_access", 32'(access_count), 32'(MAXC));
    chk("sat_stall", 32'(stall_count), 32'(MAXC));

    run_op(3'd1, 16'h3100, 16'h0000, 1, 16'h1357, 0, '0, 1'b1);
    chk("clr_access", 32'(access_count), 32'd0);
    chk("clr_stall", 32'(stall_count), 32'd0);
    chk("clr_rdata", 32'(rdata), 32'h1357);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
